// File: rtl/iir_biquad_cascade.sv
// Cascade of N_STAGES direct-form-I biquads, one section per sample-clock stage, with a
// shadow/active coefficient bank. Define IIR_SAT_STICKY_EN to enable the sticky clamp flag.
module iir_biquad_cascade #(
    parameter int unsigned N_STAGES  = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 18,
    parameter int unsigned FRAC_BITS = 14
) (
    input  logic                          lrclk_posedge,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic signed [DATA_W-1:0]      audio_in,
    input  logic                          coef_we,
    input  logic [$clog2(N_STAGES*5)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    input  logic                          coef_commit,
    output logic                          commit_ack,
    output logic signed [DATA_W-1:0]      audio_out,
    output logic                          o_valid,
    input  logic                          sat_clr,
    output logic                          o_sat_sticky
);

    localparam int unsigned NumCoef = N_STAGES * 5;
    localparam int unsigned AddrW   = $clog2(NumCoef);
    localparam int unsigned AccW    = DATA_W + COEF_W + 3;

    localparam logic [AddrW-1:0] LastAddr = AddrW'(NumCoef - 1);
    localparam logic signed [COEF_W-1:0] Unity =
        {{(COEF_W-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
    localparam logic signed [AccW-1:0] RoundHalf =
        {{(AccW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [AccW-1:0] YMax = {{(AccW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AccW-1:0] YMin = {{(AccW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic                     valid_q;
    logic [N_STAGES-1:0]      vpipe_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] x1_q [N_STAGES];
    logic signed [DATA_W-1:0] x2_q [N_STAGES];
    logic signed [DATA_W-1:0] y_q  [N_STAGES];
    logic signed [DATA_W-1:0] y2_q [N_STAGES];
    logic signed [DATA_W-1:0] u_w  [N_STAGES];
    logic signed [DATA_W-1:0] y_d  [N_STAGES];
    logic signed [COEF_W-1:0] shadow_q [NumCoef];
    logic signed [COEF_W-1:0] active_q [NumCoef];
`ifdef IIR_SAT_STICKY_EN
    logic [N_STAGES-1:0]      clamp_w;
`endif

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic signed [AccW-1:0] acc;
        logic signed [AccW-1:0] rounded;
        logic                   hi;
        logic                   lo;

        if (k == 0) begin : g_first
            assign u_w[k] = x_q;
        end else begin : g_chain
            assign u_w[k] = y_q[k-1];
        end

        // y_q doubles as the y1 history: the clamped output is the next y1.
        assign acc = AccW'(active_q[5*k+0]) * AccW'(u_w[k])
                   + AccW'(active_q[5*k+1]) * AccW'(x1_q[k])
                   + AccW'(active_q[5*k+2]) * AccW'(x2_q[k])
                   - AccW'(active_q[5*k+3]) * AccW'(y_q[k])
                   - AccW'(active_q[5*k+4]) * AccW'(y2_q[k]);
        assign rounded = (acc + RoundHalf) >>> FRAC_BITS;
        assign hi      = rounded > YMax;
        assign lo      = rounded < YMin;
        assign y_d[k]  = hi ? YMax[DATA_W-1:0] : (lo ? YMin[DATA_W-1:0] : rounded[DATA_W-1:0]);
`ifdef IIR_SAT_STICKY_EN
        assign clamp_w[k] = hi | lo;
`endif
    end

    always_ff @(posedge lrclk_posedge or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            vpipe_q    <= '0;
            x_q        <= '0;
            commit_ack <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                x1_q[k] <= '0;
                x2_q[k] <= '0;
                y_q[k]  <= '0;
                y2_q[k] <= '0;
            end
            for (int i = 0; i < NumCoef; i++) begin
                shadow_q[i] <= (i % 5 == 0) ? Unity : '0;
                active_q[i] <= (i % 5 == 0) ? Unity : '0;
            end
        end else begin
            valid_q    <= i_valid;
            vpipe_q    <= N_STAGES'({vpipe_q, valid_q});
            commit_ack <= coef_commit;
            // Non-blocking copy: a same-edge shadow write is not part of this commit.
            if (coef_commit) begin
                active_q <= shadow_q;
            end
            if (coef_we && (coef_addr <= LastAddr)) begin
                shadow_q[coef_addr] <= coef_data;
            end
            if (valid_q) begin
                x_q <= audio_in;
                for (int k = 0; k < N_STAGES; k++) begin
                    x1_q[k] <= u_w[k];
                    x2_q[k] <= x1_q[k];
                    y_q[k]  <= y_d[k];
                    y2_q[k] <= y_q[k];
                end
            end else begin
                x_q <= '0;
                for (int k = 0; k < N_STAGES; k++) begin
                    x1_q[k] <= '0;
                    x2_q[k] <= '0;
                    y_q[k]  <= '0;
                    y2_q[k] <= '0;
                end
            end
        end
    end

    assign audio_out = y_q[N_STAGES-1];
    assign o_valid   = vpipe_q[N_STAGES-1];

`ifdef IIR_SAT_STICKY_EN
    logic sat_q;

    always_ff @(posedge lrclk_posedge or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_q <= 1'b0;
        end else if (valid_q && (|clamp_w)) begin
            sat_q <= 1'b1;
        end else if (sat_clr) begin
            sat_q <= 1'b0;
        end
    end

    assign o_sat_sticky = sat_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign o_sat_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: one-stage and two-stage instances share stimulus and are
// compared every cycle against a per-sample arithmetic model, plus hand-computed points.
module tb_iir_biquad_cascade;

    localparam int F = 14;

    logic               lrclk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] audio_in;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [17:0] coef_data;
    logic               coef_commit;
    logic               sat_clr;

    logic               d1_ack, d1_ov, d1_sat;
    logic signed [15:0] d1_out;
    logic               d2_ack, d2_ov, d2_sat;
    logic signed [15:0] d2_out;

    int checks = 0;
    int errors = 0;

    iir_biquad_cascade #(.N_STAGES(1)) u_d1 (
        .lrclk_posedge(lrclk), .i_rst_n(rst_n), .i_valid(in_valid), .audio_in(audio_in),
        .coef_we(coef_we), .coef_addr(coef_addr[2:0]), .coef_data(coef_data),
        .coef_commit(coef_commit), .commit_ack(d1_ack), .audio_out(d1_out), .o_valid(d1_ov),
        .sat_clr(sat_clr), .o_sat_sticky(d1_sat)
    );

    iir_biquad_cascade #(.N_STAGES(2)) u_d2 (
        .lrclk_posedge(lrclk), .i_rst_n(rst_n), .i_valid(in_valid), .audio_in(audio_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .commit_ack(d2_ack), .audio_out(d2_out), .o_valid(d2_ov),
        .sat_clr(sat_clr), .o_sat_sticky(d2_sat)
    );

    always #5 lrclk = ~lrclk;

    // Model state, index [0] is the one-stage instance, [1] the two-stage instance.
    bit m_vq  [2];
    int m_x   [2];
    int m_x1  [2][8];
    int m_x2  [2][8];
    int m_y   [2][8];
    int m_y2  [2][8];
    bit m_vp  [2][8];
    int m_sh  [2][40];
    int m_ac  [2][40];
    bit m_ack [2];
    bit m_sat [2];

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vq[d]  = 0;
            m_x[d]   = 0;
            m_ack[d] = 0;
            m_sat[d] = 0;
            for (int k = 0; k < 8; k++) begin
                m_x1[d][k] = 0;
                m_x2[d][k] = 0;
                m_y[d][k]  = 0;
                m_y2[d][k] = 0;
                m_vp[d][k] = 0;
            end
            for (int i = 0; i < 40; i++) begin
                m_sh[d][i] = (i % 5 == 0) ? (1 << F) : 0;
                m_ac[d][i] = m_sh[d][i];
            end
        end
    endfunction

    function automatic void model_step(bit v, int a, bit we, int addr, int data, bit cm,
                                       bit clr);
        for (int d = 0; d < 2; d++) begin
            int     n;
            bit     en;
            bit     clamped;
            int     nu [8];
            int     ny [8];
            longint acc;
            longint r;
            n       = d + 1;
            en      = m_vq[d];
            clamped = 0;
            for (int k = 0; k < 8; k++) begin
                nu[k] = 0;
                ny[k] = 0;
            end
            if (en) begin
                for (int k = 0; k < n; k++) begin
                    if (k == 0) nu[k] = m_x[d];
                    else        nu[k] = m_y[d][k-1];
                    acc = longint'(m_ac[d][5*k+0]) * nu[k]
                        + longint'(m_ac[d][5*k+1]) * m_x1[d][k]
                        + longint'(m_ac[d][5*k+2]) * m_x2[d][k]
                        - longint'(m_ac[d][5*k+3]) * m_y[d][k]
                        - longint'(m_ac[d][5*k+4]) * m_y2[d][k];
                    r = (acc + (longint'(1) << (F - 1))) >>> F;
                    if (r > 32767) begin
                        r = 32767;
                        clamped = 1;
                    end else if (r < -32768) begin
                        r = -32768;
                        clamped = 1;
                    end
                    ny[k] = int'(r);
                end
            end
            for (int k = 0; k < 8; k++) begin
                m_x2[d][k] = en ? m_x1[d][k] : 0;
                m_x1[d][k] = nu[k];
                m_y2[d][k] = en ? m_y[d][k] : 0;
                m_y[d][k]  = ny[k];
            end
            m_x[d] = en ? a : 0;
            for (int i = 7; i > 0; i--) m_vp[d][i] = m_vp[d][i-1];
            m_vp[d][0] = en;
            m_vq[d]    = v;
            m_ack[d]   = cm;
            if (cm) begin
                for (int i = 0; i < 40; i++) m_ac[d][i] = m_sh[d][i];
            end
            if (we && addr < 5 * n) m_sh[d][addr] = data;
`ifdef IIR_SAT_STICKY_EN
            if (en && clamped) m_sat[d] = 1;
            else if (clr)      m_sat[d] = 0;
`else
            m_sat[d] = 0;
`endif
        end
    endfunction

    always @(posedge lrclk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(in_valid, int'(audio_in), coef_we, int'(coef_addr), int'(coef_data),
                        coef_commit, sat_clr);
    end

    always @(negedge lrclk) begin
        chk("d1_audio_out", d1_out, m_y[0][0]);
        chk("d1_o_valid", d1_ov, m_vp[0][0]);
        chk("d1_commit_ack", d1_ack, m_ack[0]);
        chk("d1_sat_sticky", d1_sat, m_sat[0]);
        chk("d2_audio_out", d2_out, m_y[1][1]);
        chk("d2_o_valid", d2_ov, m_vp[1][1]);
        chk("d2_commit_ack", d2_ack, m_ack[1]);
        chk("d2_sat_sticky", d2_sat, m_sat[1]);
    end

    task automatic cyc(int n);
        repeat (n) @(negedge lrclk);
    endtask

    task automatic set_in(int v);
        audio_in = 16'(v);
    endtask

    task automatic wr(int a, int v);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 18'(v);
        cyc(1);
        coef_we   = 1'b0;
    endtask

    int pole_exp [5] = '{500, 250, 125, 63, 32};

    initial begin
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; audio_in = '0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; coef_commit = 1'b0; sat_clr = 1'b0;
        cyc(3);
        chk("rst_d1_out", d1_out, 0);
        chk("rst_d2_ovalid", d2_ov, 0);
        chk("rst_d2_ack", d2_ack, 0);
        rst_n = 1'b1;

        // Reset coefficients pass the signal through.
        in_valid = 1'b1;
        set_in(1234);
        cyc(2);
        chk("pt_d2_ovalid_early", d2_ov, 0);
        cyc(1);
        chk("pt_d2_ovalid", d2_ov, 1);
        chk("pt_d1_out", d1_out, 1234);
        cyc(1);
        chk("pt_d2_out", d2_out, 1234);

        // Shadow write alone changes nothing.
        wr(0, 8192);
        cyc(3);
        chk("nocommit_d1_out", d1_out, 1234);
        chk("nocommit_d2_out", d2_out, 1234);

        coef_commit = 1'b1;
        cyc(1);
        chk("commit_ack_hi", d1_ack, 1);
        chk("commit_edge_old_coef", d1_out, 1234);
        coef_commit = 1'b0;
        cyc(1);
        chk("commit_ack_lo", d1_ack, 0);
        chk("commit_halved", d1_out, 617);

        // Write and commit on the same edge: the write waits for the next commit.
        coef_we = 1'b1; coef_addr = 4'd3; coef_data = -18'sd8192; coef_commit = 1'b1;
        cyc(1);
        chk("wc_ack", d2_ack, 1);
        coef_we = 1'b0; coef_commit = 1'b0;
        cyc(3);
        chk("wc_not_active", d1_out, 617);
        coef_commit = 1'b1;
        cyc(1);
        coef_commit = 1'b0;
        cyc(1);
        chk("wc_second_commit", d1_out, 926);

        // One-sample valid drop clears everything, then the single-pole impulse response.
        in_valid = 1'b0;
        cyc(1);
        in_valid = 1'b1;
        cyc(1);
        chk("drop_d1_out", d1_out, 0);
        chk("drop_d2_out", d2_out, 0);
        chk("drop_d1_ovalid", d1_ov, 0);
        set_in(1000);
        cyc(1);
        set_in(0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("pole_seq", d1_out, pole_exp[i]);
        end

        // Gain of 4 with consecutive commits.
        wr(0, 65536);
        wr(3, 0);
        coef_commit = 1'b1;
        cyc(1);
        chk("cc_ack1", d1_ack, 1);
        cyc(1);
        chk("cc_ack2", d1_ack, 1);
        coef_commit = 1'b0;
        cyc(1);
        chk("cc_ack_lo", d1_ack, 0);
        set_in(16000);
        cyc(3);
        chk("sat_pos", d1_out, 32767);
        chk("sat_pos_d2", d2_out, 32767);
`ifdef IIR_SAT_STICKY_EN
        chk("sat_sticky_set", d1_sat, 1);
`else
        chk("sat_sticky_tied", d1_sat, 0);
`endif
        set_in(-16000);
        cyc(3);
        chk("sat_neg", d1_out, -32768);
        set_in(100);
        cyc(3);
        chk("gain4", d1_out, 400);
        set_in(0);
        cyc(3);
        sat_clr = 1'b1;
        cyc(1);
        sat_clr = 1'b0;
        chk("sat_cleared", d1_sat, 0);

        // Address 5 is stage 1 b1 on the two-stage build, out of range on the one-stage build.
        set_in(5000);
        wr(5, 8192);
        coef_commit = 1'b1;
        cyc(1);
        coef_commit = 1'b0;
        cyc(3);
        chk("oor_ignored", d1_out, 20000);
        chk("stage1_half", d2_out, 10000);

        // Asynchronous reset mid-stream.
        @(posedge lrclk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d1_out", d1_out, 0);
        chk("arst_d2_out", d2_out, 0);
        chk("arst_d2_ovalid", d2_ov, 0);
        @(negedge lrclk);
        rst_n = 1'b1;
        set_in(777);
        cyc(4);
        chk("arst_pt_d1", d1_out, 777);
        chk("arst_pt_d2", d2_out, 777);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Parametrised successor to the team's fixed single-band IIR wrappers.
- N_STAGES direct-form-I biquad sections in cascade, one section per pipeline stage, clocked once per audio sample (lrclk_posedge).
- Runtime-loadable double-buffered coefficient bank: shadow writes, atomic commit to active bank.
- Input valid registered once before use (glitch-free gating); output valid aligned with pipeline latency. Sits between the I2S receiver and the EQ mixer.

Parameters:
- N_STAGES, 2, number of cascaded biquad sections (1..8)
- DATA_W, 16, signed audio sample width
- COEF_W, 18, signed coefficient width; must satisfy COEF_W >= FRAC_BITS+2
- FRAC_BITS, 14, coefficient fractional bits (unity = 1<<FRAC_BITS)

Ports:
- lrclk_posedge  in  1  block clock; one edge per sample
- i_rst_n  in  1  reset
- i_valid  in  1  input stream valid
- audio_in  in  DATA_W  signed sample
- coef_we  in  1  shadow coefficient write strobe
- coef_addr  in  $clog2(N_STAGES*5)  stage*5 + idx; idx 0..4 = b1,b2,b3,a2,a3
- coef_data  in  COEF_W  signed coefficient
- coef_commit  in  1  copy shadow bank to active bank
- commit_ack  out  1  one-cycle pulse: commit applied
- audio_out  out  DATA_W  signed filtered sample
- o_valid  out  1  audio_out valid
- sat_clr  in  1  clear sticky saturation flag
- o_sat_sticky  out  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset i_rst_n, asynchronous, active-low; clock lrclk_posedge. All ports synchronous to lrclk_posedge.
- Reset values:
  - audio_out=0, o_valid=0, commit_ack=0, o_sat_sticky=0.
  - valid_q, x_q, all stage outputs and histories = 0.
  - Both banks: b1=1<<FRAC_BITS, all others 0 (pass-through).
- valid_q <= i_valid every edge.
- enable = valid_q.
- With enable=1 at an edge:
  - x_q <= audio_in.
  - Stage k input u_k: stage 0 uses x_q; stage k>0 uses y_{k-1} (registered).
  - Each stage updates its histories (x1,x2,y1,y2) and y_k.
- With enable=0 at an edge: x_q, every y_k and every history register cleared to 0.
- Stage arithmetic:
  - acc = b1*u + b2*x1 + b3*x2 - a2*y1 - a3*y2, full precision (DATA_W+COEF_W+3 bits).
  - Add 1<<(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The clamped value is both y_k and the next y1.
- Latency: audio_in sampled at edge n appears on audio_out after edge n+N_STAGES. audio_out = y_{N_STAGES-1}.
- o_valid = enable delayed through an N_STAGES-deep shift register (also cleared by reset).
- Coefficient writes:
  - coef_we writes coef_data into shadow[coef_addr] at the edge.
  - addr >= N_STAGES*5 is ignored.
  - The active bank is never written directly.
- Commit:
  - coef_commit=1 at an edge copies the whole shadow bank to the active bank; commit_ack=1 for the following cycle.
  - New coefficients take effect on the first computation after that edge.
  - Histories are not cleared.
- coef_we and coef_commit at the same edge: the commit copies the pre-write shadow; the write lands in shadow only and needs a later commit.
- Commits held high on consecutive edges: copy on each edge; commit_ack high on each following cycle.
- Reset mid-operation: everything returns to reset values immediately, including both banks.

Optional Feature:
- Macro IIR_SAT_STICKY_EN.
- Defined:
  - o_sat_sticky set at any enabled edge where any stage clamps.
  - Cleared by sat_clr at an edge with no clamp that edge; if set and clear coincide, set wins.
- Undefined: o_sat_sticky tied 0; sat_clr ignored; no clamp-detect logic. Clamping itself is always present.

Test Plan:
- Reset pass-through, N_STAGES=2, i_valid=1, audio_in=1234 steady -> audio_out=1234 from the 2nd edge after capture; o_valid rises 2 edges after valid_q.
- Single pole, N_STAGES=1: commit b1=8192, a2=-8192, others 0; impulse 1000 then zeros -> audio_out 500, 250, 125, 63, 32.
- Saturation, N_STAGES=1: b1=65536; audio_in=16000 -> 32767; audio_in=-16000 -> -32768; o_sat_sticky=1 (with macro); sat_clr with input 0 -> 0.
- Valid drop: mid-stream i_valid=0 for one sample -> o_valid falls; histories and outputs are 0. Resumed impulse 1000 reproduces the exact single-pole sequence.
- Commit: shadow write b1=8192 without commit -> output unchanged. Commit -> commit_ack one cycle; next sample is halved. Write plus commit on the same edge -> the written value is not active until a second commit.
- Async reset asserted mid-stream: all outputs 0 immediately; after release, filter is pass-through.
